vga_pattern_sequencer: RTL

Drives the 2-bit pattern-select input of the VGA colour-bar generator, replacing the raw switches. It advances the pattern on a debounced push-button press or automatically every DWELL_FRAMES frames. All selection changes are applied only at frame start (vsync falling edge), so a pattern never switches mid-frame. It sits between the board keys/switches and the VGA generator, in the same clock domain as the generator's input clock.

---
 rtl/vga_pattern_sequencer_if.sv | 21 ++
 rtl/vga_pattern_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer_if.sv
// Pattern-sequencer bus: board-side controls in, pattern select and strobes out.
// master = the side driving the controls (board/bench), slave = the sequencer.
interface vga_pattern_sequencer_if;
    logic       vsync;
    logic       btn_n;
    logic       auto_en;
    logic       freeze;
    logic [1:0] pattern_sel;
    logic       sel_update;
    logic       frame_tick;

    modport master (
        output vsync, btn_n, auto_en, freeze,
        input  pattern_sel, sel_update, frame_tick
    );

    modport slave (
        input  vsync, btn_n, auto_en, freeze,
        output pattern_sel, sel_update, frame_tick
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Pattern-select sequencer for the VGA colour-bar generator: debounced button
// or timed auto-advance, with every change applied only at frame start.
module vga_pattern_sequencer #(
    parameter int DWELL_FRAMES    = 60,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    vga_pattern_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam int              DBW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0]  DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      DWELL_LAST = 8'(DWELL_FRAMES - 1);

    // vs_sr[1:0] is the synchroniser, vs_sr[2] the edge register
    logic [2:0]     vs_sr;
    logic [1:0]     bt_sr;
    logic           vs_fall;
    logic           frame_tick_q;

    logic [DBW-1:0] db_cnt;
    logic           btn_db;
    logic           btn_sync;
    logic           db_expire;
    logic           press_evt;

    state_t         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [7:0]     dwell_q, dwell_d;
    logic           pend_q, pend_d;
    logic           upd_q, upd_d;

    assign vs_fall  = vs_sr[2] & ~vs_sr[1];
    assign btn_sync = bt_sr[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_sr        <= 3'b111;
            bt_sr        <= 2'b11;
            frame_tick_q <= 1'b0;
        end else begin
            vs_sr        <= {vs_sr[1:0], bus.vsync};
            bt_sr        <= {bt_sr[0], bus.btn_n};
            frame_tick_q <= vs_fall;
        end
    end

    // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    assign db_expire = (btn_sync != btn_db) && (db_cnt == DB_LAST);
    assign press_evt = db_expire && !btn_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            btn_db <= 1'b1;
        end else if (btn_sync == btn_db) begin
            db_cnt <= '0;
        end else if (db_expire) begin
            db_cnt <= '0;
            btn_db <= btn_sync;
        end else begin
            db_cnt <= db_cnt + DBW'(1);
        end
    end

    always_comb begin
        state_d = MANUAL;
        if (bus.freeze)
            state_d = FROZEN;
        else if (bus.auto_en)
            state_d = AUTO;
    end

    always_comb begin
        sel_d   = sel_q;
        dwell_d = dwell_q;
        pend_d  = pend_q;
        upd_d   = 1'b0;

        if (frame_tick_q) begin
            // pending press is consumed by every frame, serviced or discarded
            pend_d = 1'b0;
            case (state_q)
                MANUAL: begin
                    if (pend_q) begin
                        sel_d = sel_q + 2'd1;
                        upd_d = 1'b1;
                    end
                end
                AUTO: begin
                    if (pend_q || dwell_q == DWELL_LAST) begin
                        sel_d   = sel_q + 2'd1;
                        upd_d   = 1'b1;
                        dwell_d = 8'd0;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        // a press landing on the frame_tick clock waits for the next frame
        if (press_evt)
            pend_d = 1'b1;

        if (state_d == AUTO && state_q != AUTO)
            dwell_d = 8'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MANUAL;
            sel_q   <= 2'd0;
            dwell_q <= 8'd0;
            pend_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            pend_q  <= pend_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.pattern_sel = sel_q;
    assign bus.sel_update  = upd_q;
    assign bus.frame_tick  = frame_tick_q;

endmodule
